// File: rtl/tiled_matrix_multiplier.sv
// rtl/tiled_matrix_multiplier.sv - tiled N x N signed matrix multiplier with NT*NT lockstep MAC lanes
// Optional MATMUL_SAT_EN: saturating, sticky-clamped accumulation instead of modulo wrap.
module tiled_matrix_multiplier #(
  parameter int N     = 10,
  parameter int T     = 4,
  parameter int W     = 32,
  parameter int ACC_W = 2*W + $clog2(N),
  parameter int IDX_W = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_sel,
  input  logic [IDX_W-1:0] ld_i,
  input  logic [IDX_W-1:0] ld_j,
  input  logic [W-1:0]     ld_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rd_i,
  input  logic [IDX_W-1:0] rd_j,
  output logic [ACC_W-1:0] rd_data
);

  localparam int NT = (N + T - 1) / T;
  localparam int L  = NT * NT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]     a_mem [N][N];
  logic signed [W-1:0]     b_mem [N][N];
  logic        [ACC_W-1:0] r_mem [N][N];

  logic [AW-1:0] k_q;
  logic [TW-1:0] r_q, c_q;
  logic          last_k, last_c, last_r, last_step;

  logic signed [ACC_W-1:0] acc_q  [L];
  logic signed [ACC_W-1:0] sum_d  [L];
  logic [L-1:0]            wr_en;
  logic [AW-1:0]           wr_row [L];
  logic [AW-1:0]           wr_col [L];

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [L-1:0] sat_q, sat_d;
`endif

  logic ld_fire, ld_in_range;

  assign last_k    = (k_q == AW'(N - 1));
  assign last_c    = (c_q == TW'(T - 1));
  assign last_r    = (r_q == TW'(T - 1));
  assign last_step = last_k && last_c && last_r;

  // start wins over a simultaneous load
  assign ld_fire     = ld_valid && ld_ready && !start;
  assign ld_in_range = (ld_i < IDX_W'(N)) && (ld_j < IDX_W'(N));

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    ld_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        ld_ready = 1'b1;
        if (start) state_d = S_RUN;
        else if (ld_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand storage survives reset.
  always_ff @(posedge clk) begin
    if (!rst && ld_fire && ld_in_range) begin
      if (ld_sel) b_mem[AW'(ld_i)][AW'(ld_j)] <= ld_data;
      else        a_mem[AW'(ld_i)][AW'(ld_j)] <= ld_data;
    end
  end

  always_comb begin
    wr_en = '0;
`ifdef MATMUL_SAT_EN
    sat_d = sat_q;
`endif
    for (int l = 0; l < L; l++) begin
      sum_d[l]  = '0;
      wr_row[l] = '0;
      wr_col[l] = '0;
    end
    for (int ti = 0; ti < NT; ti++) begin
      for (int tj = 0; tj < NT; tj++) begin
        int row, col, l;
        logic signed [W-1:0]     a_op, b_op;
        logic signed [2*W-1:0]   prod;
        logic signed [ACC_W-1:0] prod_ext;
`ifdef MATMUL_SAT_EN
        logic [ACC_W:0] wide;
`endif
        l   = ti * NT + tj;
        row = ti * T + int'(r_q);
        col = tj * T + int'(c_q);
        // padded rows/columns feed zeros and are masked from the R write
        a_op     = (row < N) ? a_mem[AW'(row)][k_q] : '0;
        b_op     = (col < N) ? b_mem[k_q][AW'(col)] : '0;
        prod     = a_op * b_op;
        prod_ext = ACC_W'(prod);
`ifdef MATMUL_SAT_EN
        wide = {acc_q[l][ACC_W-1], acc_q[l]} + {prod_ext[ACC_W-1], prod_ext};
        if (sat_q[l]) begin
          sum_d[l] = acc_q[l];
        end else if (wide[ACC_W] != wide[ACC_W-1]) begin
          sum_d[l] = wide[ACC_W] ? SAT_MIN : SAT_MAX;
          sat_d[l] = 1'b1;
        end else begin
          sum_d[l] = wide[ACC_W-1:0];
        end
`else
        sum_d[l] = acc_q[l] + prod_ext;
`endif
        wr_en[l]  = last_k && (row < N) && (col < N);
        wr_row[l] = AW'(row);
        wr_col[l] = AW'(col);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      for (int l = 0; l < L; l++) acc_q[l] <= '0;
`ifdef MATMUL_SAT_EN
      sat_q <= '0;
`endif
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          r_mem[i][j] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RUN) begin
        if (last_k) begin
          k_q <= '0;
          if (last_c) begin
            c_q <= '0;
            r_q <= last_r ? '0 : r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
        for (int l = 0; l < L; l++) begin
          acc_q[l] <= last_k ? '0 : sum_d[l];
          if (wr_en[l]) r_mem[wr_row[l]][wr_col[l]] <= sum_d[l];
        end
`ifdef MATMUL_SAT_EN
        sat_q <= last_k ? '0 : sat_d;
`endif
      end
    end
  end

  assign rd_data = ((rd_i < IDX_W'(N)) && (rd_j < IDX_W'(N))) ? r_mem[AW'(rd_i)][AW'(rd_j)] : '0;

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// tb/tb_tiled_matrix_multiplier.sv - randomized/directed bench for tiled_matrix_multiplier against an arithmetic reference
module tb_tiled_matrix_multiplier;

  localparam int N     = 10;
  localparam int T     = 4;
  localparam int W     = 32;
  localparam int ACC_W = 2*W + $clog2(N);
  localparam int IDX_W = $clog2(N+1);
  localparam int RUN_CYCLES = T*T*N;
  localparam int SW    = 8;
  localparam int SACC  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, ld_valid, ld_ready, ld_sel, start, busy, done;
  logic [IDX_W-1:0] ld_i, ld_j, rd_i, rd_j;
  logic [W-1:0]     ld_data;
  logic [ACC_W-1:0] rd_data;

  logic             s_ld_valid, s_ld_ready, s_ld_sel, s_start, s_busy, s_done;
  logic [IDX_W-1:0] s_ld_i, s_ld_j, s_rd_i, s_rd_j;
  logic [SW-1:0]    s_ld_data;
  logic [SACC-1:0]  s_rd_data;

  tiled_matrix_multiplier #(.N(N), .T(T), .W(W), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data)
  );

  tiled_matrix_multiplier #(.N(N), .T(T), .W(SW), .ACC_W(SACC), .IDX_W(IDX_W)) dut_small (
    .clk(clk), .rst(rst), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_sel(s_ld_sel),
    .ld_i(s_ld_i), .ld_j(s_ld_j), .ld_data(s_ld_data), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_i(s_rd_i), .rd_j(s_rd_j), .rd_data(s_rd_data)
  );

  logic signed [W-1:0] ma [N][N];
  logic signed [W-1:0] mb [N][N];
  logic [ACC_W-1:0]    mr [N][N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // R[i][j] = sum_k A[i][k]*B[k][j], taken modulo 2^ACC_W
  function automatic void compute_model();
    logic signed [ACC_W-1:0] ea, eb;
    logic [ACC_W-1:0] s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) begin
          ea = ma[i][k];
          eb = mb[k][j];
          s  = s + ea * eb;
        end
        mr[i][j] = s;
      end
  endfunction

  task automatic load(input bit sel, input int i, input int j, input logic [W-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_i     = IDX_W'(i);
    ld_j     = IDX_W'(j);
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (i < N && j < N) begin
      if (sel) mb[i][j] = d;
      else     ma[i][j] = d;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        load(1'b0, i, j, ma[i][j]);
        load(1'b1, i, j, mb[i][j]);
      end
    compute_model();
  endtask

  // poke_at >= 0: at that RUN cycle attempt start plus an A[0][0]=99 load
  task automatic run_wait(input bit load_with_start, input int poke_at, output int cyc, output int busy_cnt);
    start = 1'b1;
    if (load_with_start) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_i = '0; ld_j = '0; ld_data = 77;
    end
    @(posedge clk); #1;
    start = 1'b0;
    ld_valid = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < RUN_CYCLES + 40) begin
      if (busy) busy_cnt++;
      if (cyc == poke_at) begin
        start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_i = '0; ld_j = '0; ld_data = 99;
        #1 check("run_ld_ready", ld_ready, 1'b0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      ld_valid = 1'b0;
      cyc++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rd_i = IDX_W'(i);
        rd_j = IDX_W'(j);
        #1 check($sformatf("%s[%0d][%0d]", tag, i, j), rd_data, mr[i][j]);
      end
  endtask

  initial begin
    int cyc, bc;
    logic [ACC_W-1:0] neg150;
    longint exact, s_exp;

    rst = 1'b1; ld_valid = 0; ld_sel = 0; ld_i = '0; ld_j = '0; ld_data = '0; start = 0;
    rd_i = '0; rd_j = '0;
    s_ld_valid = 0; s_ld_sel = 0; s_ld_i = '0; s_ld_j = '0; s_ld_data = '0; s_start = 0;
    s_rd_i = '0; s_rd_j = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ld_ready", ld_ready, 1'b1);
    check("reset_rd", rd_data, '0);

    // identity A with B[i][j] = i*10+j
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i*10 + j;
      end
    load_all();
    run_wait(1'b0, -1, cyc, bc);
    check("ident_latency", cyc, RUN_CYCLES);
    check("ident_busy_cycles", bc, RUN_CYCLES);
    check("ident_busy_after", busy, 1'b0);
    check("ident_done", done, 1'b1);
    check_all("ident");

    // all ones, including dropped out-of-range loads
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 1;
        mb[i][j] = 1;
      end
    load_all();
    load(1'b0, 10, 3, 55);
    load(1'b1, 2, 10, 55);
    run_wait(1'b0, -1, cyc, bc);
    check("ones_latency", cyc, RUN_CYCLES);
    check_all("ones");
    rd_i = 10; rd_j = 3;
    #1 check("rd_oob_row", rd_data, '0);
    rd_i = 3; rd_j = 10;
    #1 check("rd_oob_col", rd_data, '0);

    // signed row/column; a load coinciding with start is dropped
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == 0) ? -3 : 0;
        mb[i][j] = (j == 0) ? 5 : 0;
      end
    load_all();
    load(1'b0, 5, 5, 0);
    run_wait(1'b1, -1, cyc, bc);
    check("signed_latency", cyc, RUN_CYCLES);
    neg150 = -150;
    rd_i = 0; rd_j = 0;
    #1 check("signed_r00", rd_data, neg150);
    check_all("signed");

    // random operands, disturbed by start+load at RUN cycle 20
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom();
        mb[i][j] = $urandom();
      end
    load_all();
    run_wait(1'b0, 20, cyc, bc);
    check("poke_latency", cyc, RUN_CYCLES);
    check("poke_busy_cycles", bc, RUN_CYCLES);
    check_all("rand_poke");

    // restart from DONE recomputes from current operands
    run_wait(1'b0, -1, cyc, bc);
    check("restart_latency", cyc, RUN_CYCLES);
    check_all("restart");

    // a load accepted in DONE returns to IDLE
    load(1'b0, 0, 0, ma[0][0]);
    check("done_drop", done, 1'b0);
    check("idle_ld_ready", ld_ready, 1'b1);

    // new random B, reset at RUN cycle 50, then rerun without reloading
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        load(1'b1, i, j, $urandom());
    compute_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ld_ready", ld_ready, 1'b1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rd_i = IDX_W'(i);
        rd_j = IDX_W'(j);
        #1 check($sformatf("abort_zero[%0d][%0d]", i, j), rd_data, '0);
      end
    run_wait(1'b0, -1, cyc, bc);
    check("after_abort_latency", cyc, RUN_CYCLES);
    check_all("after_abort");

    // narrow instance: all 127, overflow of a 16-bit accumulator
    for (int sel = 0; sel < 2; sel++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          s_ld_valid = 1'b1;
          s_ld_sel   = sel[0];
          s_ld_i     = IDX_W'(i);
          s_ld_j     = IDX_W'(j);
          s_ld_data  = 8'sd127;
          @(posedge clk); #1;
          s_ld_valid = 1'b0;
        end
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < RUN_CYCLES + 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ovf_latency", cyc, RUN_CYCLES);
    exact = 0;
    for (int k = 0; k < N; k++) exact += 127 * 127;
`ifdef MATMUL_SAT_EN
    s_exp = (exact > 32767) ? 32767 : exact;
`else
    s_exp = exact % 65536;
`endif
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s_rd_i = IDX_W'(i);
        s_rd_j = IDX_W'(j);
        #1 check($sformatf("ovf[%0d][%0d]", i, j), s_rd_data, s_exp[SACC-1:0]);
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiled_matrix_multiplier.md
Name: tiled_matrix_multiplier

Overview:
- Parametrised successor to the fixed-size parallel multiplier: computes R = A x B for N x N signed matrices.
- Uses NT x NT lockstep MAC lanes, where NT = ceil(N/T); each lane owns one T x T output tile. N need not be a multiple of T.
- Operands are loaded through a write port, not a file. Results are read back through a combinational read port.
- Sits between the host/loader logic and result consumers in the matrix datapath.

Parameters:
N, 10, matrix dimension
T, 4, tile edge; lanes = NT*NT, NT = ceil(N/T)
W, 32, operand width, signed two's complement
ACC_W, 2*W+$clog2(N), accumulator and result width
IDX_W, $clog2(N+1), width of row/column index ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_valid  in  1  operand write request
ld_ready  out  1  1 when a write is accepted (state IDLE or DONE)
ld_sel  in  1  0 = write A, 1 = write B
ld_i  in  IDX_W  row index
ld_j  in  IDX_W  column index
ld_data  in  W  operand value
start  in  1  begin multiply (sampled level)
busy  out  1  1 while in RUN
done  out  1  1 in DONE: R is valid
rd_i  in  IDX_W  result row
rd_j  in  IDX_W  result column
rd_data  out  ACC_W  R[rd_i][rd_j], combinational; 0 if rd_i>=N or rd_j>=N

Behaviour:
- Reset: synchronous, active-high on clk.
  - State goes to IDLE; busy=0, done=0, ld_ready=1 from the cycle after reset.
  - All counters and lane accumulators are cleared; all R entries are cleared to 0.
  - A and B contents are retained.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE after the final step.
  - DONE -> RUN when start=1.
  - DONE -> IDLE when a load is accepted (done drops the next cycle).
- Load: accepted when ld_valid=1 and ld_ready=1; writes A or B [ld_i][ld_j] at that edge.
  - If ld_i>=N or ld_j>=N, the write is dropped silently.
  - When start and ld_valid are both 1 in the same cycle, start has priority and the load is dropped.
- RUN: one shared step counter (r, c, k), with k innermost (0..N-1), then c (0..T-1), then r (0..T-1).
  - Each step, lane (ti, tj) adds A[ti*T+r][k] * B[k][tj*T+c] to its accumulator.
  - The product is full 2W signed, sign-extended to ACC_W; the add wraps modulo 2^ACC_W.
  - When k=N-1, the lane writes its final sum to R[ti*T+r][tj*T+c] and clears its accumulator.
  - Padded lanes and rows/columns (index >= N) compute but never write R.
- Latency: if start is sampled at edge E, RUN lasts T*T*N cycles and the last R write happens at edge E+T*T*N.
  - busy=1 after edge E through edge E+T*T*N-1.
  - done=1 from edge E+T*T*N.
- Ignored in RUN: start, and ld_valid (ld_ready=0).
- Reset mid-RUN aborts the run; reset rules apply (R cleared to 0).
- Restart from DONE recomputes R from the current A and B.

Optional Feature:
MATMUL_SAT_EN:
- Defined: each accumulate saturates to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A saturated lane stays clamped for the rest of that element.
- Undefined: plain modulo-2^ACC_W wrap; no saturation logic is built.

Test Plan:
1. Identity: N=10, T=4, A=I, B[i][j]=i*10+j; start at edge 0 -> done rises at edge 160, busy=1 for 160 cycles, every rd_data equals B[i][j].
2. Padding: A and B all 1 -> every R[i][j]=10 for i,j<10; reading rd_i=10, rd_j=3 -> 0; padded lanes never corrupt R.
3. Signed: A[0][k]=-3, B[k][0]=5 for all k, all other entries 0 -> R[0][0]=-150, all other R entries 0.
4. Busy protection: pulse start and ld_valid (ld_sel=0, ld_data=99) at cycle 20 of RUN -> ld_ready=0, A unchanged, done still rises at edge 160, results unchanged.
5. Reset mid-run: assert rst at RUN cycle 50 -> busy=0, done=0, all rd_data 0. A new start then gives a correct result 160 cycles later without reloading.
6. Overflow: W=8, ACC_W=16, all A and B entries =127 -> without MATMUL_SAT_EN R=30218 (161290 mod 65536); with it R=32767.
